// File: rtl/pm_cmd_seq.sv
// pm_cmd_seq: one-command-at-a-time sequencer between a decode strobe and a
// datapath action port. IDLE accepts a one-hot command, ISSUE holds the action
// request until the datapath takes it, HOLD waits HOLD_CYC settle cycles.
// Optional build macro PM_CMD_SEQ_TIMEOUT_EN: abandons an ISSUE that waits
// TIMEOUT cycles without act_ready, pulsing err and leaving cmd_cnt untouched.
module pm_cmd_seq #(
  parameter int HOLD_CYC = 3,
  parameter int TIMEOUT  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dec_valid,
  input  logic [3:0] dec_cmd,
  output logic       dec_ready,
  output logic       act_valid,
  output logic [1:0] act_code,
  input  logic       act_ready,
  output logic       busy,
  output logic       err,
  output logic [7:0] cmd_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] hold_cnt, hold_nxt;
  logic [1:0] code_q, code_nxt;
  logic [7:0] cnt_q, cnt_nxt;
  logic       err_q, err_nxt;
  logic       busy_q;
  logic       cmd_onehot;
  logic [1:0] cmd_idx;

`ifdef PM_CMD_SEQ_TIMEOUT_EN
  logic [7:0] wait_cnt, wait_nxt;
`endif

  // Command legality and bit-index encoding of the decoded command
  always_comb begin
    cmd_onehot = (dec_cmd != 4'd0) && ((dec_cmd & (dec_cmd - 4'd1)) == 4'd0);
    cmd_idx    = 2'd0;
    if (dec_cmd[1]) cmd_idx = 2'd1;
    if (dec_cmd[2]) cmd_idx = 2'd2;
    if (dec_cmd[3]) cmd_idx = 2'd3;
  end

  // Next-state and next-register values
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    code_nxt  = code_q;
    cnt_nxt   = cnt_q;
    err_nxt   = 1'b0;
`ifdef PM_CMD_SEQ_TIMEOUT_EN
    wait_nxt  = wait_cnt;
`endif
    case (state)
      IDLE: begin
        if (dec_valid) begin
          if (cmd_onehot) begin
            code_nxt  = cmd_idx;
            state_nxt = ISSUE;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (act_ready) begin
          cnt_nxt = cnt_q + 8'd1;
`ifdef PM_CMD_SEQ_TIMEOUT_EN
          wait_nxt = 8'd0;
`endif
          if (HOLD_CYC == 0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = HOLD;
            hold_nxt  = 4'(HOLD_CYC);
          end
        end
`ifdef PM_CMD_SEQ_TIMEOUT_EN
        // Handshake above has priority; only a stalled cycle can time out
        else if (wait_cnt == 8'(TIMEOUT - 1)) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
          wait_nxt  = 8'd0;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
`endif
      end
      HOLD: begin
        // Leaving when the counter shows 1 gives HOLD_CYC cycles in HOLD
        if (hold_cnt <= 4'd1) begin
          state_nxt = IDLE;
          hold_nxt  = 4'd0;
        end else begin
          hold_nxt = hold_cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        hold_nxt  = 4'd0;
      end
    endcase
  end

  // State and output registers; reset beats any same-cycle handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= 4'd0;
      code_q   <= 2'd0;
      cnt_q    <= 8'd0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      code_q   <= code_nxt;
      cnt_q    <= cnt_nxt;
      err_q    <= err_nxt;
      busy_q   <= (state_nxt != IDLE);
    end
  end

`ifdef PM_CMD_SEQ_TIMEOUT_EN
  // Stall counter for the ISSUE timeout
  always_ff @(posedge clk) begin
    if (rst) wait_cnt <= 8'd0;
    else     wait_cnt <= wait_nxt;
  end
`endif

  assign dec_ready = (state == IDLE);
  assign act_valid = (state == ISSUE);
  assign act_code  = code_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign cmd_cnt   = cnt_q;

endmodule

// File: tb/tb_pm_cmd_seq.sv
// Bench for pm_cmd_seq: two instances (HOLD_CYC=3 and HOLD_CYC=0) share one
// directed stimulus; a cycle-level model checks both every cycle, and literal
// expectations pin the worked examples.
module tb_pm_cmd_seq;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dec_valid = 1'b0;
  logic [3:0] dec_cmd = 4'd0;
  logic       act_ready = 1'b0;

  logic       d_ready [2];
  logic       d_avalid[2];
  logic [1:0] d_code  [2];
  logic       d_busy  [2];
  logic       d_err   [2];
  logic [7:0] d_cnt   [2];

  int checks   = 0;
  int failures = 0;
  bit mdl_on   = 1'b0;

  always #5 clk = ~clk;

  pm_cmd_seq #(.HOLD_CYC(3), .TIMEOUT(TO)) u0 (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_cmd(dec_cmd),
    .dec_ready(d_ready[0]), .act_valid(d_avalid[0]), .act_code(d_code[0]),
    .act_ready(act_ready), .busy(d_busy[0]), .err(d_err[0]), .cmd_cnt(d_cnt[0])
  );

  pm_cmd_seq #(.HOLD_CYC(0), .TIMEOUT(TO)) u1 (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_cmd(dec_cmd),
    .dec_ready(d_ready[1]), .act_valid(d_avalid[1]), .act_code(d_code[1]),
    .act_ready(act_ready), .busy(d_busy[1]), .err(d_err[1]), .cmd_cnt(d_cnt[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Model: a command is either pending (issuing) or the sequencer is
  // unavailable for a number of remaining cycles after the handshake.
  bit       m_issue[2];
  int       m_code [2];
  int       m_left [2];
  int       m_cnt  [2];
  bit       m_err  [2];
  int       m_wc   [2];

  function automatic int hold_of(input int i);
    return (i == 0) ? 3 : 0;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_issue[i] = 0; m_code[i] = 0; m_left[i] = 0;
        m_cnt[i] = 0; m_err[i] = 0; m_wc[i] = 0;
      end else begin
        m_err[i] = 0;
        if (m_issue[i]) begin
          if (act_ready) begin
            m_issue[i] = 0;
            m_cnt[i]   = (m_cnt[i] + 1) % 256;
            m_left[i]  = hold_of(i);
            m_wc[i]    = 0;
          end else begin
`ifdef PM_CMD_SEQ_TIMEOUT_EN
            m_wc[i] = m_wc[i] + 1;
            if (m_wc[i] == TO) begin
              m_issue[i] = 0;
              m_err[i]   = 1;
              m_wc[i]    = 0;
            end
`endif
          end
        end else if (m_left[i] > 0) begin
          m_left[i] = m_left[i] - 1;
        end else if (dec_valid) begin
          if ($countones(dec_cmd) == 1) begin
            m_issue[i] = 1;
            for (int b = 0; b < 4; b++) if (dec_cmd[b]) m_code[i] = b;
          end else begin
            m_err[i] = 1;
          end
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (mdl_on) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("u%0d.dec_ready", i), d_ready[i], (!m_issue[i] && m_left[i] == 0));
        chk($sformatf("u%0d.act_valid", i), d_avalid[i], m_issue[i]);
        if (m_issue[i]) chk($sformatf("u%0d.act_code", i), d_code[i], m_code[i]);
        chk($sformatf("u%0d.busy", i), d_busy[i], (m_issue[i] || m_left[i] > 0));
        chk($sformatf("u%0d.err", i), d_err[i], m_err[i]);
        chk($sformatf("u%0d.cmd_cnt", i), d_cnt[i], m_cnt[i]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_out(input int n);
    dec_valid = 1'b0;
    act_ready = 1'b1;
    for (int k = 0; k < n; k++) step();
  endtask

  logic [3:0] vec_cmd[8];

  initial begin
    vec_cmd[0] = 4'b0001; vec_cmd[1] = 4'b0010; vec_cmd[2] = 4'b0100;
    vec_cmd[3] = 4'b1000; vec_cmd[4] = 4'b0000; vec_cmd[5] = 4'b0011;
    vec_cmd[6] = 4'b1111; vec_cmd[7] = 4'b1000;

    // Reset state
    rst = 1'b1;
    step();
    mdl_on = 1'b1;
    step();
    @(negedge clk);
    chk("rst.dec_ready", d_ready[0], 1);
    chk("rst.act_valid", d_avalid[0], 0);
    chk("rst.act_code", d_code[0], 0);
    chk("rst.busy", d_busy[0], 0);
    chk("rst.cmd_cnt", d_cnt[0], 0);

    // Worked example: shift command, immediate handshake, 3 settle cycles
    rst = 1'b0; dec_valid = 1'b1; dec_cmd = 4'b0100; act_ready = 1'b1;
    step();                       // cycle 1
    dec_valid = 1'b0;
    @(negedge clk);
    chk("ex1.act_valid", d_avalid[0], 1);
    chk("ex1.act_code", d_code[0], 2);
    step(); step();               // cycle 3
    @(negedge clk);
    chk("ex1.ready_c3", d_ready[0], 0);
    step();                       // cycle 4
    @(negedge clk);
    chk("ex1.ready_c4", d_ready[0], 0);
    step();                       // cycle 5
    @(negedge clk);
    chk("ex1.ready_c5", d_ready[0], 1);
    chk("ex1.cmd_cnt", d_cnt[0], 1);

    // Multi-hot command: one-cycle error, nothing issued
    dec_valid = 1'b1; dec_cmd = 4'b0110;
    step();
    dec_valid = 1'b0;
    @(negedge clk);
    chk("bad.err", d_err[0], 1);
    chk("bad.act_valid", d_avalid[0], 0);
    chk("bad.dec_ready", d_ready[0], 1);
    step();
    @(negedge clk);
    chk("bad.err_clr", d_err[0], 0);
    chk("bad.cmd_cnt", d_cnt[0], 1);

    // Stalled datapath: 10 cycles without act_ready, then accept
    dec_valid = 1'b1; dec_cmd = 4'b0001; act_ready = 1'b0;
    step();
    dec_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
`ifndef PM_CMD_SEQ_TIMEOUT_EN
      @(negedge clk);
      chk("stall.act_valid", d_avalid[0], 1);
      chk("stall.act_code", d_code[0], 0);
`endif
      step();
    end
    act_ready = 1'b1;
    step();
`ifndef PM_CMD_SEQ_TIMEOUT_EN
    @(negedge clk);
    chk("stall.cmd_cnt", d_cnt[0], 2);
    chk("stall.act_valid_drop", d_avalid[0], 0);
`endif
    idle_out(5);

    // Directed mix: dec_valid held through busy periods, act_ready toggling
    for (int v = 0; v < 8; v++) begin
      dec_valid = 1'b1;
      dec_cmd   = vec_cmd[v];
      for (int k = 0; k < 7; k++) begin
        act_ready = ((k + v) % 3) != 0;
        step();
      end
    end
    idle_out(6);

    // Wrap: back-to-back commands on the HOLD_CYC=0 instance
    rst = 1'b1;
    step();
    rst = 1'b0; dec_valid = 1'b1; dec_cmd = 4'b1000; act_ready = 1'b1;
    for (int k = 0; k < 510; k++) step();
    @(negedge clk);
    chk("wrap.cnt_255", d_cnt[1], 255);
    step(); step();
    @(negedge clk);
    chk("wrap.cnt_0", d_cnt[1], 0);
    idle_out(6);

    // Reset while in HOLD
    dec_valid = 1'b1; dec_cmd = 4'b0010; act_ready = 1'b1;
    step(); step();               // accept, then handshake -> HOLD
    dec_valid = 1'b0;
    @(negedge clk);
    chk("rsthold.in_hold", d_busy[0], 1);
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("rsthold.dec_ready", d_ready[0], 1);
    chk("rsthold.act_valid", d_avalid[0], 0);
    chk("rsthold.busy", d_busy[0], 0);
    chk("rsthold.err", d_err[0], 0);
    chk("rsthold.cmd_cnt", d_cnt[0], 0);
    rst = 1'b0;

    // Reset in ISSUE coincident with act_ready
    dec_valid = 1'b1; dec_cmd = 4'b1000; act_ready = 1'b0;
    step();
    dec_valid = 1'b0;
    @(negedge clk);
    chk("rstiss.in_issue", d_avalid[0], 1);
    rst = 1'b1; act_ready = 1'b1;
    step();
    @(negedge clk);
    chk("rstiss.dec_ready", d_ready[0], 1);
    chk("rstiss.act_valid", d_avalid[0], 0);
    chk("rstiss.act_code", d_code[0], 0);
    chk("rstiss.busy", d_busy[0], 0);
    chk("rstiss.cmd_cnt", d_cnt[0], 0);
    rst = 1'b0;
    idle_out(4);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pm_cmd_seq.md
PM_CMD_SEQ -- requirements
Module: pm_cmd_seq

Interface
REQ-001 Parameter HOLD_CYC, default 3: post-issue settle cycles (0..15).
REQ-002 Parameter TIMEOUT, default 16: ISSUE-state wait limit in cycles (1..255). Used only with PM_CMD_SEQ_TIMEOUT_EN.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 dec_valid  input  1  upstream decode strobe valid.
REQ-006 dec_cmd  input  4  decoded command, one-hot: bit0 load, bit1 compare, bit2 shift, bit3 clear.
REQ-007 dec_ready  output  1  sequencer can accept a command.
REQ-008 act_valid  output  1  action request to datapath.
REQ-009 act_code  output  2  binary action code, equal to index of the accepted dec_cmd bit.
REQ-010 act_ready  input  1  datapath accepts the action.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 err  output  1  one-cycle error pulse.
REQ-013 cmd_cnt  output  8  count of completed act handshakes.

Function
REQ-014 States SHALL be IDLE, ISSUE and HOLD, encoded in 2 bits; the unused code SHALL return to IDLE on the next edge.
REQ-015 dec_ready SHALL be 1 only in IDLE; an accept is dec_valid & dec_ready at a rising edge.
REQ-016 An accept with one-hot dec_cmd SHALL register act_code and move to ISSUE; act_valid SHALL be 1 in the next cycle (latency 1).
REQ-017 An accept with dec_cmd zero or multi-hot SHALL pulse err for exactly one cycle, issue nothing, and remain in IDLE.
REQ-018 In ISSUE, act_valid SHALL stay 1 and act_code SHALL stay stable until act_valid & act_ready.
REQ-019 On the act handshake, cmd_cnt SHALL increment modulo 256 (255 wraps to 0).
REQ-020 On the act handshake, the FSM SHALL enter HOLD with the hold counter set to HOLD_CYC; with HOLD_CYC=0 it SHALL go straight to IDLE.
REQ-021 In HOLD, the hold counter SHALL decrement each cycle; the FSM SHALL return to IDLE when the counter reaches 1.
REQ-022 With HOLD_CYC>0, dec_ready SHALL reassert exactly HOLD_CYC+1 cycles after the act handshake edge.
REQ-023 act_valid SHALL be 0 in IDLE and HOLD.
REQ-024 act_ready SHALL be ignored outside ISSUE.
REQ-025 dec_valid SHALL be ignored outside IDLE; no queuing.
REQ-026 busy SHALL equal (state != IDLE), driven from a register.

Reset
REQ-027 When rst=1 at an edge, state SHALL be IDLE, and act_valid, act_code, err, busy, cmd_cnt and all internal counters SHALL be 0. dec_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-028 rst SHALL take priority over every other event, including a handshake in the same cycle.
REQ-029 Reset in ISSUE or HOLD SHALL abort the command; the aborted command SHALL NOT be counted.

Configuration
REQ-030 Macro PM_CMD_SEQ_TIMEOUT_EN defined:
- An ISSUE wait counter counts cycles with act_ready=0.
- When the count reaches TIMEOUT, act_valid SHALL drop, err SHALL pulse for one cycle, the FSM SHALL return to IDLE, and cmd_cnt SHALL remain unchanged.
- A handshake in the same cycle SHALL win over the timeout.
REQ-031 Macro PM_CMD_SEQ_TIMEOUT_EN undefined:
- ISSUE SHALL wait indefinitely.
- The wait counter SHALL be absent.
- err SHALL come only from REQ-017.

Verification
REQ-032 After reset: dec_cmd=4'b0100 accepted at cycle 0, act_ready=1 -> act_valid=1 with act_code=2 at cycle 1; HOLD_CYC=3; dec_ready=1 again at cycle 5; cmd_cnt=1.
REQ-033 dec_cmd=4'b0110 accepted -> err=1 for one cycle, act_valid stays 0, dec_ready stays 1, cmd_cnt unchanged.
REQ-034 act_ready held 0 for 10 cycles, then 1 -> act_valid=1 with act_code stable throughout, one handshake, cmd_cnt+1; with macro defined and TIMEOUT=4 -> err at the 4th wait cycle, act_valid=0, cmd_cnt unchanged.
REQ-035 256 back-to-back commands with HOLD_CYC=0 -> cmd_cnt wraps to 0; one command every 2 cycles when act_ready=1.
REQ-036 rst=1 asserted in HOLD, and separately in ISSUE coincident with act_ready=1 -> next cycle all outputs 0 except dec_ready=1, cmd_cnt=0.
